// File: rtl/aabb_pair_overlap_if.sv
// Handshake bundle for the AABB pair-overlap block: AABB load stream in, overlapping index pairs out.
interface aabb_pair_overlap_if #(
    parameter int IDX_W = 3
);
    logic [31:0]      aabb0;
    logic [31:0]      aabb1;
    logic [31:0]      aabb2;
    logic [31:0]      aabb3;
    logic [31:0]      aabb4;
    logic [31:0]      aabb5;
    logic             in_stb;
    logic             in_last;
    logic             in_ack;
    logic [IDX_W-1:0] pair_i;
    logic [IDX_W-1:0] pair_j;
    logic             pair_stb;
    logic             pair_ack;
    logic             done;

    modport master (
        output aabb0, aabb1, aabb2, aabb3, aabb4, aabb5, in_stb, in_last, pair_ack,
        input  in_ack, pair_i, pair_j, pair_stb, done
    );

    modport slave (
        input  aabb0, aabb1, aabb2, aabb3, aabb4, aabb5, in_stb, in_last, pair_ack,
        output in_ack, pair_i, pair_j, pair_stb, done
    );
endinterface

// File: rtl/aabb_pair_overlap.sv
// Buffers a batch of AABBs, then scans every (i<j) pair one per cycle and emits the overlapping ones.
module aabb_pair_overlap #(
    parameter int DEPTH = 8,
    parameter int IDX_W = 3
) (
    input logic                clk,
    input logic                rst,
    aabb_pair_overlap_if.slave bus
);
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TWO   = CNT_W'(2);
    localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(DEPTH - 1);

    typedef enum logic [1:0] {LOAD, SCAN, EMIT, DONE} state_e;
    typedef logic [31:0] f32_t;

    state_e           state_q;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] n_q;
    logic [IDX_W-1:0] i_q, j_q;
    logic [IDX_W-1:0] i_d, j_d;
    logic [IDX_W-1:0] pair_i_q, pair_j_q;
    logic             pair_stb_q;
    logic             done_q;
    logic             in_ack_q;
    logic             accept;
    logic             overlap;
    logic             last_j;
    logic             last_pair;

    f32_t ent_q [DEPTH][6];

    function automatic logic is_nan(input f32_t v);
        return (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
    endfunction

    // Sign-magnitude a <= b; both zeros compare equal regardless of sign.
    function automatic logic f_le(input f32_t a, input f32_t b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b1;
        if (a[31] != b[31])                       return a[31];
        if (!a[31])                               return a[30:0] <= b[30:0];
        return a[30:0] >= b[30:0];
    endfunction

    function automatic logic axis_ovl(input f32_t amin, input f32_t amax,
                                      input f32_t bmin, input f32_t bmax);
        if (is_nan(amin) || is_nan(amax) || is_nan(bmin) || is_nan(bmax)) return 1'b0;
        return f_le(amin, bmax) && f_le(bmin, amax);
    endfunction

    assign accept = in_ack_q && bus.in_stb;

    assign overlap =
        axis_ovl(ent_q[i_q][0], ent_q[i_q][1], ent_q[j_q][0], ent_q[j_q][1]) &&
        axis_ovl(ent_q[i_q][2], ent_q[i_q][3], ent_q[j_q][2], ent_q[j_q][3]) &&
        axis_ovl(ent_q[i_q][4], ent_q[i_q][5], ent_q[j_q][4], ent_q[j_q][5]);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        last_j    = ({1'b0, j_q} == n_q - CNT_ONE);
        last_pair = last_j && ({1'b0, i_q} == n_q - CNT_TWO);
        i_d       = i_q;
        j_d       = j_q + 1'b1;
        if (last_j) begin
            i_d = i_q + 1'b1;
            j_d = i_q + IDX_W'(2);
        end
    end

    // NOTE: the entry buffer is plain storage that is always written before it is read, so it has no reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            ent_q[count_q[IDX_W-1:0]][0] <= bus.aabb0;
            ent_q[count_q[IDX_W-1:0]][1] <= bus.aabb1;
            ent_q[count_q[IDX_W-1:0]][2] <= bus.aabb2;
            ent_q[count_q[IDX_W-1:0]][3] <= bus.aabb3;
            ent_q[count_q[IDX_W-1:0]][4] <= bus.aabb4;
            ent_q[count_q[IDX_W-1:0]][5] <= bus.aabb5;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LOAD;
            count_q    <= '0;
            n_q        <= '0;
            i_q        <= '0;
            j_q        <= IDX_W'(1);
            pair_i_q   <= '0;
            pair_j_q   <= '0;
            pair_stb_q <= 1'b0;
            done_q     <= 1'b0;
            in_ack_q   <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    if (accept) begin
                        count_q <= count_q + CNT_ONE;
                        if (bus.in_last || count_q == LAST_SLOT) begin
                            state_q  <= SCAN;
                            n_q      <= count_q + CNT_ONE;
                            i_q      <= '0;
                            j_q      <= IDX_W'(1);
                            in_ack_q <= 1'b0;
                        end
                    end
                end
                SCAN: begin
                    if (n_q < CNT_TWO) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else if (overlap) begin
                        pair_i_q   <= i_q;
                        pair_j_q   <= j_q;
                        pair_stb_q <= 1'b1;
                        state_q    <= EMIT;
                    end else if (last_pair) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end else begin
                        i_q <= i_d;
                        j_q <= j_d;
                    end
                end
                EMIT: begin
                    if (bus.pair_ack) begin
                        pair_stb_q <= 1'b0;
                        if (last_pair) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            i_q     <= i_d;
                            j_q     <= j_d;
                            state_q <= SCAN;
                        end
                    end
                end
                DONE: begin
                    done_q   <= 1'b0;
                    count_q  <= '0;
                    in_ack_q <= 1'b1;
                    state_q  <= LOAD;
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign bus.in_ack   = in_ack_q;
    assign bus.pair_i   = pair_i_q;
    assign bus.pair_j   = pair_j_q;
    assign bus.pair_stb = pair_stb_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_aabb_pair_overlap.sv
// Self-checking bench for aabb_pair_overlap: vector table of box pairs plus hand-written batch sequences.
module tb_aabb_pair_overlap;
    localparam int DEPTH = 8;
    localparam int IDX_W = 3;
    localparam logic [31:0] P1 = 32'h3F80_0000;
    localparam logic [31:0] M1 = 32'hBF80_0000;

    typedef logic [5:0][31:0] box_t;
    typedef struct packed {
        logic [IDX_W-1:0] i;
        logic [IDX_W-1:0] j;
    } pair_t;
    typedef struct {
        string name;
        box_t  a;
        box_t  b;
        bit    ovl;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    n_checks = 0;
    int    n_errors = 0;
    pair_t exp_q[$];
    vec_t  vecs[10];
    box_t  unit, box_a, box_b, box_c;

    aabb_pair_overlap_if #(.IDX_W(IDX_W)) bus ();

    aabb_pair_overlap #(.DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic box_t mk(input logic [31:0] x0, input logic [31:0] x1,
                                input logic [31:0] y0, input logic [31:0] y1,
                                input logic [31:0] z0, input logic [31:0] z1);
        box_t b;
        b[0] = x0; b[1] = x1; b[2] = y0; b[3] = y1; b[4] = z0; b[5] = z1;
        return b;
    endfunction

    function automatic pair_t mkp(input int i, input int j);
        pair_t p;
        p.i = IDX_W'(i);
        p.j = IDX_W'(j);
        return p;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one box until accepted (bounded), then withdraw it.
    task automatic load_box(input box_t b, input bit last, input string name);
        int waited = 0;
        bus.aabb0 = b[0]; bus.aabb1 = b[1]; bus.aabb2 = b[2];
        bus.aabb3 = b[3]; bus.aabb4 = b[4]; bus.aabb5 = b[5];
        bus.in_stb  = 1'b1;
        bus.in_last = last;
        while (!bus.in_ack && waited < 50) begin
            tick();
            waited++;
        end
        check({name, " in_ack"}, 32'(bus.in_ack), 32'd1);
        tick();
        bus.in_stb  = 1'b0;
        bus.in_last = 1'b0;
    endtask

    // Consume pairs against the scoreboard until done; optionally stall the first pair.
    task automatic drain(input string name, input int hold_first);
        int    cyc = 0;
        bit    got_done = 1'b0;
        bit    first = 1'b1;
        pair_t got, want;
        bus.pair_ack = 1'b0;
        while (!got_done && cyc < 400) begin
            if (bus.done) begin
                got_done = 1'b1;
            end else if (bus.pair_stb) begin
                got.i = bus.pair_i;
                got.j = bus.pair_j;
                if (first) begin
                    for (int h = 0; h < hold_first; h++) begin
                        tick();
                        cyc++;
                        check({name, " hold stb"}, 32'(bus.pair_stb), 32'd1);
                        check({name, " hold pair"}, 32'({bus.pair_i, bus.pair_j}), 32'(got));
                    end
                end
                first = 1'b0;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL %s unexpected pair: got (%0d,%0d), expected none", name, got.i, got.j);
                end else begin
                    want = exp_q.pop_front();
                    check({name, " pair"}, 32'(got), 32'(want));
                end
                bus.pair_ack = 1'b1;
                tick();
                cyc++;
                bus.pair_ack = 1'b0;
            end else begin
                tick();
                cyc++;
            end
        end
        check({name, " done seen"}, 32'(got_done), 32'd1);
        check({name, " pairs left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        if (got_done) begin
            tick();
            check({name, " done pulse"}, 32'(bus.done), 32'd0);
            check({name, " reload ack"}, 32'(bus.in_ack), 32'd1);
        end
    endtask

    initial begin
        int bad;
        int waited;
        bus.in_stb = 1'b0; bus.in_last = 1'b0; bus.pair_ack = 1'b0;
        bus.aabb0 = '0; bus.aabb1 = '0; bus.aabb2 = '0;
        bus.aabb3 = '0; bus.aabb4 = '0; bus.aabb5 = '0;

        unit  = mk(M1, P1, M1, P1, M1, P1);
        box_a = unit;
        box_b = mk(32'h3F00_0000, 32'h4020_0000, M1, P1, M1, P1);
        box_c = mk(32'h4020_0000, 32'h4060_0000, M1, P1, M1, P1);

        vecs[0] = '{name:"same",         a:unit, b:unit, ovl:1'b1};
        vecs[1] = '{name:"nan_x",        a:unit, b:mk(32'h7FC0_0000, P1, M1, P1, M1, P1), ovl:1'b0};
        vecs[2] = '{name:"zero_sign",    a:mk(M1, 32'h8000_0000, M1, P1, M1, P1),
                                         b:mk(32'h0000_0000, P1, M1, P1, M1, P1), ovl:1'b1};
        vecs[3] = '{name:"sep_y",        a:unit, b:mk(M1, P1, 32'h4000_0000, 32'h4040_0000, M1, P1), ovl:1'b0};
        vecs[4] = '{name:"neg_sep",      a:mk(32'hC040_0000, 32'hC000_0000, M1, P1, M1, P1), b:unit, ovl:1'b0};
        vecs[5] = '{name:"neg_touch",    a:mk(32'hC040_0000, M1, M1, P1, M1, P1), b:unit, ovl:1'b1};
        vecs[6] = '{name:"inverted_ovl", a:mk(P1, M1, M1, P1, M1, P1), b:unit, ovl:1'b1};
        vecs[7] = '{name:"inverted_sep", a:mk(32'h4000_0000, 32'hC000_0000, M1, P1, M1, P1), b:unit, ovl:1'b0};
        vecs[8] = '{name:"nan_z",        a:unit, b:mk(M1, P1, M1, P1, M1, 32'h7F80_0001), ovl:1'b0};
        vecs[9] = '{name:"neg_inf_sep",  a:unit, b:mk(32'hFF80_0000, 32'hC000_0000, M1, P1, M1, P1), ovl:1'b0};

        tick();
        tick();
        rst = 1'b0;
        check("reset in_ack",   32'(bus.in_ack),   32'd1);
        check("reset pair_stb", 32'(bus.pair_stb), 32'd0);
        check("reset done",     32'(bus.done),     32'd0);
        check("reset pair_i",   32'(bus.pair_i),   32'd0);
        check("reset pair_j",   32'(bus.pair_j),   32'd0);

        // Three-box batch with a stalled consumer on the first pair.
        exp_q.push_back(mkp(0, 1));
        exp_q.push_back(mkp(1, 2));
        load_box(box_a, 1'b0, "abc A");
        load_box(box_b, 1'b0, "abc B");
        load_box(box_c, 1'b1, "abc C");
        drain("abc", 5);

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].ovl) exp_q.push_back(mkp(0, 1));
            load_box(vecs[v].a, 1'b0, {vecs[v].name, " a"});
            load_box(vecs[v].b, 1'b1, {vecs[v].name, " b"});
            drain(vecs[v].name, 0);
        end

        // NaN pair: no emission, done two cycles after acceptance.
        load_box(unit, 1'b0, "nan_lat a");
        load_box(vecs[1].b, 1'b1, "nan_lat b");
        check("nan_lat cyc1 done", 32'(bus.done), 32'd0);
        tick();
        check("nan_lat cyc2 done", 32'(bus.done), 32'd1);
        check("nan_lat stb",       32'(bus.pair_stb), 32'd0);
        tick();
        check("nan_lat pulse",     32'(bus.done), 32'd0);

        // Single-entry batch.
        load_box(unit, 1'b1, "single");
        check("single cyc1 done", 32'(bus.done), 32'd0);
        check("single cyc1 ack",  32'(bus.in_ack), 32'd0);
        tick();
        check("single cyc2 done", 32'(bus.done), 32'd1);
        check("single stb",       32'(bus.pair_stb), 32'd0);
        tick();
        check("single pulse",     32'(bus.done), 32'd0);

        // Full buffer without in_last: all 28 pairs in lexicographic order.
        for (int i = 0; i < DEPTH; i++)
            for (int j = i + 1; j < DEPTH; j++)
                exp_q.push_back(mkp(i, j));
        for (int k = 0; k < DEPTH; k++) load_box(unit, 1'b0, "full load");
        check("full in_ack drop", 32'(bus.in_ack), 32'd0);
        drain("full", 0);

        // Reset while a pair is pending.
        load_box(box_a, 1'b0, "rst A");
        load_box(box_b, 1'b0, "rst B");
        load_box(box_c, 1'b1, "rst C");
        waited = 0;
        while (!bus.pair_stb && waited < 20) begin
            tick();
            waited++;
        end
        check("rst pre stb", 32'(bus.pair_stb), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst stb",    32'(bus.pair_stb), 32'd0);
        check("rst in_ack", 32'(bus.in_ack),   32'd1);
        check("rst done",   32'(bus.done),     32'd0);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.pair_stb || bus.done) bad++;
            tick();
        end
        check("rst quiet", 32'(bad), 32'd0);

        exp_q.push_back(mkp(0, 1));
        load_box(unit, 1'b0, "post_rst a");
        load_box(unit, 1'b1, "post_rst b");
        drain("post_rst", 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/aabb_pair_overlap.md
AABB_PAIR_OVERLAP -- requirements
Module: aabb_pair_overlap

Interface
REQ-001 Parameter DEPTH, default 8, is the maximum number of AABBs buffered per batch (2..16).
REQ-002 Parameter IDX_W, default 3, is the entry index width, with 2**IDX_W >= DEPTH.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 aabb0..aabb5  input  32 each  IEEE-754 single values xmin, xmax, ymin, ymax, zmin, zmax, in the same order the AABB compute stage produces them.
REQ-006 in_stb  input  1  the upstream AABB is valid.
REQ-007 in_last  input  1  qualifies in_stb; the entry is the final entry of the batch.
REQ-008 in_ack  output  1  the block accepts an AABB this cycle.
REQ-009 pair_i, pair_j  output  IDX_W each  indices of an overlapping pair, with pair_i < pair_j.
REQ-010 pair_stb  output  1  pair_i and pair_j are valid.
REQ-011 pair_ack  input  1  the consumer takes the pair.
REQ-012 done  output  1  one-cycle pulse when the batch scan is complete.

Function
REQ-013 The FSM states SHALL be LOAD, SCAN, EMIT and DONE.
REQ-014 LOAD: in_ack = 1; an entry is accepted when in_stb && in_ack; it is written to entry[count], and count increments.
REQ-015 LOAD exit: on acceptance with in_last = 1, or when count reaches DEPTH, the block SHALL go to SCAN with n = count, i = 0, j = 1; in_ack SHALL be 0 in every state except LOAD.
REQ-016 SCAN evaluates exactly one pair (i,j) per cycle, with i ascending, j ascending, and j > i.
REQ-017 On overlap, SCAN SHALL register pair_i = i and pair_j = j and go to EMIT, so pair_stb is asserted the next cycle.
REQ-018 Without overlap, SCAN advances: j+1, or when j = n-1 then i+1 and j = i+2.
REQ-019 After the final pair (i = n-2, j = n-1) SCAN goes to DONE, either directly or via EMIT.
REQ-020 If n = 1, the block SHALL go from SCAN to DONE in one cycle with no pair_stb.
REQ-021 EMIT: pair_stb = 1, with pair_i and pair_j held stable until pair_ack = 1; on the ack cycle the block advances as in REQ-018 and returns to SCAN, or to DONE after the final pair.
REQ-022 pair_ack SHALL be ignored when pair_stb = 0.
REQ-023 DONE: done = 1 for exactly one cycle; then count = 0 and the block returns to LOAD.
REQ-024 Overlap SHALL be A.min <= B.max AND B.min <= A.max on all three axes; touching (equality) counts as overlap.
REQ-025 The float <= compare SHALL be sign-magnitude: +0 and -0 are equal; for two negatives, the larger magnitude is the smaller value.
REQ-026 Any NaN operand (exponent 0xFF with nonzero mantissa) SHALL make the pair non-overlapping.
REQ-027 Min > max inputs SHALL be compared as given, without swapping.
REQ-028 The compare SHALL be combinational from the buffer registers, with no FP-core instances.
REQ-029 Inputs arriving while not in LOAD SHALL be ignored (not acknowledged); upstream holds them.

Reset
REQ-030 With rst = 1 at an edge, the block SHALL go to state LOAD with count = 0, i = 0, j = 1, pair_stb = 0, pair_i = pair_j = 0, and done = 0.
REQ-031 in_ack SHALL be 1 in the first cycle after reset.
REQ-032 Buffer contents need no reset.
REQ-033 Reset mid-SCAN or mid-EMIT SHALL abort the batch with no further pair_stb or done.

Verification
REQ-034 The bench SHALL cover these 3-entry loads, with entries A, B, C in load order:
- A = {BF800000,3F800000,BF800000,3F800000,BF800000,3F800000}.
- B = {3F000000,40200000,BF800000,3F800000,BF800000,3F800000}.
- C = {40200000,40600000,BF800000,3F800000,BF800000,3F800000}, with in_last.
- Required response: pairs (0,1) then (1,2), where (1,2) is a touch at 2.5, then done; (0,2) is never emitted.
REQ-035 Hold pair_ack = 0 for 5 cycles during the REQ-034 test -> pair_stb stays 1 with (0,1) stable; then ack -> (1,2) follows.
REQ-036 Load DEPTH = 8 identical boxes without in_last -> in_ack drops after the 8th entry, 28 pairs are emitted in lexicographic order, then a done pulse.
REQ-037 Two boxes, where box 1 has xmin = 7FC00000 (NaN) -> no pair_stb, done 2 cycles after SCAN entry; separately, xmax = 80000000 vs xmin = 00000000 -> overlap emitted.
REQ-038 Single entry with in_last -> done exactly 2 cycles after acceptance, no pair_stb; assert rst during EMIT of REQ-034 -> pair_stb = 0 and in_ack = 1 the next cycle, and no done.
